// File: rtl/bldc_hall_tracker_pkg.sv
// Hall code constants, code-to-step-index decode and mod-6 transition classification.
// Pure combinational helpers shared by the tracker; no state, no flow control.
package bldc_hall_pkg;

    localparam logic [2:0] HALL_IDX0     = 3'b101;
    localparam logic [2:0] HALL_IDX1     = 3'b100;
    localparam logic [2:0] HALL_IDX2     = 3'b110;
    localparam logic [2:0] HALL_IDX3     = 3'b010;
    localparam logic [2:0] HALL_IDX4     = 3'b011;
    localparam logic [2:0] HALL_IDX5     = 3'b001;
    localparam logic [2:0] HALL_BAD0     = 3'b000;
    localparam logic [2:0] HALL_BAD7     = 3'b111;
    localparam logic [2:0] HALL_IDX_NONE = 3'd7;

    typedef enum logic [2:0] {NONE, FWD, REV, SKIP, INVALID, RESYNC} hall_trans_e;

    function automatic logic [2:0] hall_index(input logic [2:0] code);
        logic [2:0] idx;
        case (code)
            HALL_IDX0: idx = 3'd0;
            HALL_IDX1: idx = 3'd1;
            HALL_IDX2: idx = 3'd2;
            HALL_IDX3: idx = 3'd3;
            HALL_IDX4: idx = 3'd4;
            HALL_IDX5: idx = 3'd5;
            default:   idx = HALL_IDX_NONE;
        endcase
        return idx;
    endfunction

    // Only meaningful when old_code != new_code; old_valid=0 whenever old_code is illegal.
    function automatic hall_trans_e hall_classify(input logic [2:0] old_code,
                                                  input logic [2:0] new_code,
                                                  input logic       old_valid);
        logic [2:0]  oi;
        logic [2:0]  ni;
        logic [3:0]  delta;
        hall_trans_e t;
        oi    = hall_index(old_code);
        ni    = hall_index(new_code);
        delta = (ni >= oi) ? {1'b0, ni - oi} : ({1'b0, ni} + 4'd6 - {1'b0, oi});
        if (new_code == HALL_BAD0 || new_code == HALL_BAD7) t = INVALID;
        else if (!old_valid)                                t = RESYNC;
        else if (delta == 4'd1)                             t = FWD;
        else if (delta == 4'd5)                             t = REV;
        else                                                t = SKIP;
        return t;
    endfunction

endpackage

// File: rtl/bldc_hall_tracker_filter.sv
// Two-flop synchroniser plus stability-count glitch filter; a code is accepted after
// FILTER_CYCLES identical synchronised samples (edge N+1+F), FILTER_CYCLES=0 bypasses.
module hall_glitch_filter #(
    parameter int WIDTH         = 3,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign dout = sync2_q;
        end else begin : g_filter
            localparam int              CW    = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0]   F_MAX = CW'(FILTER_CYCLES);

            logic [WIDTH-1:0] cand_q, cand_d;
            logic [WIDTH-1:0] filt_q, filt_d;
            logic [CW-1:0]    stab_q, stab_d;

            // The mismatching sample itself is the first sample of the new run.
            always_comb begin
                cand_d = sync2_q;
                filt_d = filt_q;
                if (sync2_q != cand_q)   stab_d = CW'(1);
                else if (stab_q == F_MAX) stab_d = stab_q;
                else                      stab_d = stab_q + CW'(1);
                if (stab_d == F_MAX) filt_d = sync2_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cand_q <= '0;
                    filt_q <= '0;
                    stab_q <= '0;
                end else begin
                    cand_q <= cand_d;
                    filt_q <= filt_d;
                    stab_q <= stab_d;
                end
            end

            assign dout = filt_q;
        end
    endgenerate

endmodule

// File: rtl/bldc_hall_tracker.sv
// Hall position tracker: filtered hall code -> signed step count, direction, step pulse, sticky errors.
// count/dir/step update at edge N+2+FILTER_CYCLES; BLDC_HALL_PERIOD_EN adds step-period/stall measurement.
module bldc_hall_tracker
    import bldc_hall_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int PERIOD_WIDTH  = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               hall,
    input  logic                     count_clr,
    input  logic                     err_clr,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     dir,
    output logic                     step,
    output logic                     invalid_err,
    output logic                     skip_err,
    output logic [2:0]               hall_filt
`ifdef BLDC_HALL_PERIOD_EN
    ,
    output logic [PERIOD_WIDTH-1:0]  period,
    output logic                     period_valid,
    output logic                     stall
`endif
);

    logic [2:0]               filt_code;
    logic [2:0]               hall_filt_d_q, hall_filt_d_d;
    logic                     prev_valid_q, prev_valid_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     dir_q, dir_d;
    logic                     step_q, step_d;
    logic                     invalid_err_q, invalid_err_d;
    logic                     skip_err_q, skip_err_d;
    logic                     inv_set, skip_set;
    hall_trans_e              trans;

    hall_glitch_filter #(
        .WIDTH         (3),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk   (clk),
        .reset (reset),
        .din   (hall),
        .dout  (filt_code)
    );

    always_comb begin
        trans = NONE;
        if (filt_code != hall_filt_d_q)
            trans = hall_classify(hall_filt_d_q, filt_code, prev_valid_q);
        hall_filt_d_d = filt_code;
        prev_valid_d  = prev_valid_q;
        count_d       = count_q;
        dir_d         = dir_q;
        step_d        = 1'b0;
        inv_set       = 1'b0;
        skip_set      = 1'b0;
        case (trans)
            FWD: begin
                count_d = count_q + COUNTER_WIDTH'(1);
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end
            REV: begin
                count_d = count_q - COUNTER_WIDTH'(1);
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end
            SKIP:    skip_set = 1'b1;
            INVALID: begin
                inv_set      = 1'b1;
                prev_valid_d = 1'b0;
            end
            RESYNC:  prev_valid_d = 1'b1;
            default: ;
        endcase
        // Clear beats a coincident step; set beats a coincident error clear.
        if (count_clr) count_d = '0;
        invalid_err_d = inv_set  | (invalid_err_q & ~err_clr);
        skip_err_d    = skip_set | (skip_err_q    & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hall_filt_d_q <= '0;
            prev_valid_q  <= 1'b0;
            count_q       <= '0;
            dir_q         <= 1'b0;
            step_q        <= 1'b0;
            invalid_err_q <= 1'b0;
            skip_err_q    <= 1'b0;
        end else begin
            hall_filt_d_q <= hall_filt_d_d;
            prev_valid_q  <= prev_valid_d;
            count_q       <= count_d;
            dir_q         <= dir_d;
            step_q        <= step_d;
            invalid_err_q <= invalid_err_d;
            skip_err_q    <= skip_err_d;
        end
    end

    assign count       = count_q;
    assign dir         = dir_q;
    assign step        = step_q;
    assign invalid_err = invalid_err_q;
    assign skip_err    = skip_err_q;
    assign hall_filt   = filt_code;

`ifdef BLDC_HALL_PERIOD_EN
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

    logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    period_valid_q, period_valid_d;
    logic                    stall_q, stall_d;

    // Restarted only by counted steps; resync and error transitions let it keep running.
    always_comb begin
        pcnt_d         = pcnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stall_d        = stall_q;
        if (step_d) begin
            period_d       = pcnt_q;
            pcnt_d         = PERIOD_WIDTH'(1);
            period_valid_d = 1'b1;
            stall_d        = 1'b0;
        end else if (pcnt_q == PERIOD_MAX) begin
            stall_d  = 1'b1;
            period_d = PERIOD_MAX;
        end else begin
            pcnt_d = pcnt_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stall_q        <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stall_q        <= stall_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stall        = stall_q;
`endif

endmodule

// File: tb/tb_bldc_hall_tracker.sv
// Bench for bldc_hall_tracker: directed scenarios plus random hall traffic, checked every cycle
// against a pin-history / step-index reference model; a 4-bit-count instance checks wrap-around.
module tb_bldc_hall_tracker;

    localparam int F    = 4;
    localparam int CW   = 16;
    localparam int PW   = 8;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          count_clr = 1'b0;
    logic          err_clr = 1'b0;
    logic [2:0]    hall = 3'b000;
    logic [CW-1:0] count;
    logic          dir, step, invalid_err, skip_err;
    logic [2:0]    hall_filt;
    logic [3:0]    count_s;
    logic          dir_s, step_s, inv_s, skip_s;
    logic [2:0]    filt_s;
`ifdef BLDC_HALL_PERIOD_EN
    logic [PW-1:0] period, period_s;
    logic          period_valid, pv_s, stall, stall_s;
`endif

    bldc_hall_tracker #(.COUNTER_WIDTH(CW), .FILTER_CYCLES(F), .PERIOD_WIDTH(PW)) u_dut (
        .clk(clk), .reset(reset), .hall(hall), .count_clr(count_clr), .err_clr(err_clr),
        .count(count), .dir(dir), .step(step), .invalid_err(invalid_err), .skip_err(skip_err),
        .hall_filt(hall_filt)
`ifdef BLDC_HALL_PERIOD_EN
        , .period(period), .period_valid(period_valid), .stall(stall)
`endif
    );

    bldc_hall_tracker #(.COUNTER_WIDTH(4), .FILTER_CYCLES(F), .PERIOD_WIDTH(PW)) u_dut_small (
        .clk(clk), .reset(reset), .hall(hall), .count_clr(count_clr), .err_clr(err_clr),
        .count(count_s), .dir(dir_s), .step(step_s), .invalid_err(inv_s), .skip_err(skip_s),
        .hall_filt(filt_s)
`ifdef BLDC_HALL_PERIOD_EN
        , .period(period_s), .period_valid(pv_s), .stall(stall_s)
`endif
    );

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;

    logic [2:0]    seq_codes [6];
    logic [2:0]    pin_hist [8];
    logic [2:0]    m_filt1, m_filt2;
    logic          m_prev_valid, m_dir, m_step, m_inv, m_skip;
    logic [CW-1:0] m_count;
    int            m_pc;
    logic [PW-1:0] m_period;
    logic          m_pv, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (seq_codes[i] == c) return i;
        return -1;
    endfunction

    // Reference: filtered code = value of a run of F identical pin samples seen through 2 sync stages;
    // each change of the filtered code is judged one edge later by step-index distance mod 6.
    task automatic model_edge();
        int         oi, ni, d;
        logic       run, counted, inv_ev, skip_ev;
        logic [2:0] nf;
        if (reset) begin
            for (int k = 0; k < 8; k++) pin_hist[k] = 3'b000;
            m_filt1 = 0; m_filt2 = 0; m_prev_valid = 0; m_count = 0; m_dir = 0; m_step = 0;
            m_inv = 0; m_skip = 0; m_pc = 0; m_period = 0; m_pv = 0; m_stall = 0;
            return;
        end
        for (int k = 7; k > 0; k--) pin_hist[k] = pin_hist[k-1];
        pin_hist[0] = hall;
        counted = 0; inv_ev = 0; skip_ev = 0; m_step = 0; m_pv = 0;
        if (m_filt1 != m_filt2) begin
            ni = idx_of(m_filt1);
            oi = idx_of(m_filt2);
            if (ni < 0) begin
                inv_ev = 1; m_prev_valid = 0;
            end else if (!m_prev_valid) begin
                m_prev_valid = 1;
            end else begin
                d = (ni - oi + 6) % 6;
                if (d == 1)      begin m_count = m_count + 1; m_dir = 1; counted = 1; end
                else if (d == 5) begin m_count = m_count - 1; m_dir = 0; counted = 1; end
                else skip_ev = 1;
            end
        end
        m_step = counted;
        if (count_clr) m_count = 0;
        m_inv  = inv_ev  | (m_inv  & !err_clr);
        m_skip = skip_ev | (m_skip & !err_clr);
        if (counted) begin
            m_period = PW'(m_pc); m_pc = 1; m_pv = 1; m_stall = 0;
        end else if (m_pc == PMAX) begin
            m_stall = 1; m_period = PW'(PMAX);
        end else begin
            m_pc = m_pc + 1;
        end
        if (F == 0) begin
            nf = pin_hist[1];
        end else begin
            run = 1;
            for (int k = 2; k <= F + 1; k++)
                if (pin_hist[k] != pin_hist[2]) run = 0;
            nf = run ? pin_hist[2] : m_filt1;
        end
        m_filt2 = m_filt1;
        m_filt1 = nf;
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(m_count));
        check("dir", 32'(dir), 32'(m_dir));
        check("step", 32'(step), 32'(m_step));
        check("invalid_err", 32'(invalid_err), 32'(m_inv));
        check("skip_err", 32'(skip_err), 32'(m_skip));
        check("hall_filt", 32'(hall_filt), 32'(m_filt1));
        check("count_small", 32'(count_s), 32'(m_count[3:0]));
        check("step_small", 32'(step_s), 32'(m_step));
        check("dir_small", 32'(dir_s), 32'(m_dir));
        check("errs_small", 32'({inv_s, skip_s}), 32'({m_inv, m_skip}));
        check("filt_small", 32'(filt_s), 32'(m_filt1));
`ifdef BLDC_HALL_PERIOD_EN
        check("period", 32'(period), 32'(m_period));
        check("period_valid", 32'(period_valid), 32'(m_pv));
        check("stall", 32'(stall), 32'(m_stall));
        check("period_small", 32'({period_s, pv_s, stall_s}), 32'({m_period, m_pv, m_stall}));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
        if (step) step_cnt++;
    endtask

    task automatic hold_code(input logic [2:0] c, input int n);
        hall = c;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int         lat, c0, sc0, cur, n;
        logic       got;
        logic [2:0] c;
        seq_codes[0] = 3'b101; seq_codes[1] = 3'b100; seq_codes[2] = 3'b110;
        seq_codes[3] = 3'b010; seq_codes[4] = 3'b011; seq_codes[5] = 3'b001;

        // Reset state
        repeat (3) tick();
        check("rst_count", 32'(count), 0);
        check("rst_flags", 32'({dir, step, invalid_err, skip_err}), 0);
        reset = 1'b0;

        // Forward revolution with per-step latency
        hold_code(3'b101, 20);
        check("resync_no_count", 32'(count), 0);
        step_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            hall = seq_codes[i % 6];
            lat = 0; got = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (step && !got) begin got = 1; lat = k; end
            end
            check("fwd_latency", 32'(lat), 7);
        end
        check("fwd_count", 32'(count), 6);
        check("fwd_dir", 32'(dir), 1);
        check("fwd_steps", 32'(step_cnt), 6);
        check("fwd_no_err", 32'({invalid_err, skip_err}), 0);

        // Reverse below zero
        do_reset();
        hold_code(3'b101, 20);
        hold_code(3'b001, 20);
        hold_code(3'b011, 20);
        check("rev_count", 32'(count), 32'h0000FFFE);
        check("rev_dir", 32'(dir), 0);

        // Signed overflow on the 4-bit instance: 7 -> 8
        do_reset();
        hold_code(3'b101, 20);
        for (int i = 1; i <= 7; i++) hold_code(seq_codes[i % 6], 20);
        check("small_at_7", 32'(count_s), 7);
        hold_code(seq_codes[2], 20);
        check("small_wrap_8", 32'(count_s), 8);
        check("wide_at_8", 32'(count), 8);

        // Short glitch must not pass the filter
        hold_code(3'b100, 20);
        c0 = int'(count); sc0 = step_cnt;
        hold_code(3'b110, 3);
        hold_code(3'b100, 20);
        check("glitch_filt", 32'(hall_filt), 32'(3'b100));
        check("glitch_count", 32'(count), 32'(c0));
        check("glitch_no_step", 32'(step_cnt), 32'(sc0));

        // Skip, invalid, resync, err_clr vs coincident new skip
        hold_code(3'b010, 20);
        check("skip_set", 32'(skip_err), 1);
        check("skip_count", 32'(count), 32'(c0));
        hold_code(3'b000, 20);
        check("invalid_set", 32'(invalid_err), 1);
        hold_code(3'b011, 20);
        check("resync_count", 32'(count), 32'(c0));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_cleared", 32'({invalid_err, skip_err}), 0);
        hall = 3'b101;
        repeat (6) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("skip_set_wins", 32'(skip_err), 1);
        repeat (13) tick();

        // count_clr coincident with a forward step from 5
        do_reset();
        hold_code(3'b101, 20);
        for (int i = 1; i <= 5; i++) hold_code(seq_codes[i], 20);
        check("pre_clr_count", 32'(count), 5);
        hall = 3'b101;
        repeat (6) tick();
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_step", 32'(step), 1);
        check("clr_dir", 32'(dir), 1);
        repeat (13) tick();

`ifdef BLDC_HALL_PERIOD_EN
        for (int s = 0; s < 4; s++) begin
            hall = seq_codes[s + 1];
            for (int k = 0; k < 100; k++) begin
                tick();
                if (period_valid && s > 0) check("period_100", 32'(period), 100);
            end
        end
        repeat (300) tick();
        check("stall_set", 32'(stall), 1);
        check("stall_period", 32'(period), 32'hFF);
        hold_code(seq_codes[5], 20);
        check("stall_clear", 32'(stall), 0);
`endif

        // Random traffic: neighbour steps, jumps, illegal codes, glitches, clears and resets
        for (int it = 0; it < 600; it++) begin
            cur = idx_of(hall);
            if (cur < 0) cur = 0;
            n = int'($urandom_range(0, 99));
            if (n < 40)      c = seq_codes[(cur + 1) % 6];
            else if (n < 75) c = seq_codes[(cur + 5) % 6];
            else if (n < 90) c = seq_codes[$urandom_range(0, 5)];
            else             c = 3'($urandom_range(0, 7));
            hall = c;
            n = int'($urandom_range(1, 12));
            repeat (n) begin
                count_clr = ($urandom_range(0, 31) == 0);
                err_clr   = ($urandom_range(0, 31) == 0);
                reset     = ($urandom_range(0, 299) == 0);
                tick();
            end
            count_clr = 1'b0; err_clr = 1'b0; reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bldc_hall_tracker.md
Name: bldc_hall_tracker

Overview:
Parametrised successor to the team's hall step counter for the robot2015 BLDC FPGA path. It synchronises and glitch-filters the raw 3-bit hall inputs, then tracks signed rotor position as a step count with direction. It flags illegal hall codes and skipped steps, and can optionally measure the step period for speed estimation. It sits between the hall pins and the motor controller and SPI register bank.

Parameters:
COUNTER_WIDTH, 16, width of the position count (two's-complement, wraps).
FILTER_CYCLES, 4, number of consecutive identical synchronised samples required before a new hall code is accepted. 0 means bypass.
PERIOD_WIDTH, 20, width of the period counter. Used only with BLDC_HALL_PERIOD_EN.

Ports:
clk  input  1  system clock; the single clock domain.
reset  input  1  synchronous, active-high reset.
hall  input  3  raw asynchronous hall sensor pins.
count_clr  input  1  synchronous clear of count only.
err_clr  input  1  synchronous clear of the sticky error flags.
count  output  COUNTER_WIDTH  signed step position.
dir  output  1  direction of the last valid step: 1 = forward (up), 0 = reverse.
step  output  1  one-cycle pulse on each counted step.
invalid_err  output  1  sticky; an illegal code (000 or 111) was accepted.
skip_err  output  1  sticky; a ±2 or 3 step jump was accepted.
hall_filt  output  3  filtered hall code.
period  output  PERIOD_WIDTH  clocks between the last two valid steps (macro only).
period_valid  output  1  one-cycle pulse when period updates (macro only).
stall  output  1  period counter has saturated (macro only).

Behaviour:
- Reset values: count=0, dir=0, step=0, invalid_err=0, skip_err=0, hall_filt=0, synchroniser=0, filter state=0, prev_valid=0. With the macro: period=0, period_valid=0, stall=0.
- Synchroniser: 2-FF stage on hall. If a new pin value is first captured at edge N, the synchroniser output shows it after edge N+1.
- Filter, FILTER_CYCLES=F≥1:
  - A candidate register holds the code under test. A stability counter increments while the synchroniser output equals the candidate.
  - Any mismatch reloads the candidate and resets the counter.
  - hall_filt takes the candidate after F consecutive matching samples, i.e. at edge N+1+F for a clean transition.
  - A glitch shorter than F samples never reaches hall_filt.
- Filter, F=0: hall_filt equals the synchroniser output.
- Step decode, from the filtered code:
  - Step index order: 101=0, 100=1, 110=2, 010=3, 011=4, 001=5. Codes 000 and 111 are invalid.
  - hall_filt_d holds the previous filtered code. Evaluation happens only on the edge after hall_filt changes; results are registered, so count/dir/step update at edge N+2+F.
- Transition classes:
  - delta = +1 mod 6: count+1, dir←1, step pulse.
  - delta = −1 mod 6: count−1, dir←0, step pulse.
  - delta = ±2 or 3: count unchanged, skip_err←1, prev_valid stays 1.
  - New code invalid: count unchanged, invalid_err←1, prev_valid←0.
  - Valid code with prev_valid=0 (first code after reset, or after an invalid code): resynchronise only. No count, no error, prev_valid←1.
- Count arithmetic: modulo 2^COUNTER_WIDTH. 0x7FFF+1 → 0x8000; 0x0000−1 → 0xFFFF.
- count_clr: count←0 on the next edge. If it coincides with a step, the clear wins and the step is discarded. The step pulse and dir still update.
- err_clr: clears both sticky flags. If it coincides with a new error event, set wins.
- Reset during an active transition discards all filter and decode state. The first accepted code after reset resynchronises.

Optional Feature:
BLDC_HALL_PERIOD_EN defined:
- A period counter increments every clock and saturates at all-ones.
- On each counted step (same edge as step): period←counter value, counter←1, period_valid pulses, stall←0.
- When the counter reaches all-ones: stall←1 and period←all-ones (motor stalled).
- Resync and error transitions do not restart the counter.
- count_clr does not affect period.
- On reset the counter starts from 0.

BLDC_HALL_PERIOD_EN undefined: the period, period_valid and stall ports and all period logic are absent.

Decomposition:
- Shared package bldc_hall_pkg:
  - The six step-code constants and the two invalid codes.
  - The code-to-index decode function.
  - The mod-6 delta classification enum: NONE, FWD, REV, SKIP, INVALID, RESYNC.
- Sub-module hall_glitch_filter: the synchroniser plus the stability-counter filter, parametrised by width (3) and FILTER_CYCLES.

Test Plan:
1. Reset, F=4, then forward sequence 101→100→110→010→011→001→101, each held 20 clks → first code resyncs; count=6, dir=1, six step pulses, each at N+6 after its pin change; no errors.
2. From count=0, reverse sequence 101→001→011 (after resync on 101) → count=0xFFFE, dir=0; continue forward from 0x7FFF → 0x8000 wraps correctly.
3. 3-clk glitch 100→110→100 with F=4 → hall_filt stays 100, count unchanged, no step.
4. Jump 101→010 → skip_err=1, count unchanged. Then 000 → invalid_err=1. Then 011 → resync, no count. err_clr coincident with a new skip → skip_err stays 1.
5. count_clr asserted on the same edge as a forward step from count=5 → count=0, dir=1, step pulses.
6. With BLDC_HALL_PERIOD_EN and PERIOD_WIDTH=8:
   - Steps 100 clks apart → period=100, period_valid pulses with step.
   - No steps for 300 clks → stall=1, period=0xFF.
   - Next step → stall=0.
